// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
//   start       : master -> slave, request (sampled on rising clk)
//   dividend    : master -> slave, unsigned numerator, W bits
//   divisor     : master -> slave, unsigned denominator, W bits
//   busy        : slave -> master, division in progress
//   done        : slave -> master, one-cycle result-valid pulse
//   quotient    : slave -> master, W-bit quotient, held until next result
//   remainder   : slave -> master, W-bit remainder, held until next result
//   div_by_zero : slave -> master, set with done when divisor was zero
interface seq_restoring_divider_if #(
    parameter int W = 4
);
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seq_restoring_divider_if (start/operands in,
//           busy/done/quotient/remainder/div_by_zero out, all registered)
// A non-zero divisor yields the result W edges after acceptance; a zero
// divisor takes a one-edge shortcut through DZ and returns all-ones quotient
// with the dividend as remainder.
module seq_restoring_divider #(
    parameter int W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    seq_restoring_divider_if.slave      bus
);
    localparam int CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DZ   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W:0]    r_q, r_d;          // partial remainder, one guard bit
    logic [W-1:0]  q_q, q_d;          // dividend shifting out / quotient in
    logic [W-1:0]  div_q, div_d;      // latched divisor
    logic [CW-1:0] cnt_q, cnt_d;      // steps left after the current one
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  quotient_q, quotient_d;
    logic [W-1:0]  remainder_q, remainder_d;
    logic          dbz_q, dbz_d;

    logic [W:0]    r_shift_s;
    logic [W:0]    r_next_s;
    logic [W-1:0]  q_next_s;

    // Next-state and datapath logic for all FSM states
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        // One restoring step: shift in next dividend bit, trial-subtract.
        r_shift_s = {r_q[W-1:0], q_q[W-1]};
        if (r_shift_s >= {1'b0, div_q}) begin
            r_next_s = r_shift_s - {1'b0, div_q};
            q_next_s = {q_q[W-2:0], 1'b1};
        end else begin
            r_next_s = r_shift_s;
            q_next_s = {q_q[W-2:0], 1'b0};
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // q_q also carries the dividend into DZ for the remainder.
                    busy_d = 1'b1;
                    q_d    = bus.dividend;
                    div_d  = bus.divisor;
                    r_d    = {(W+1){1'b0}};
                    cnt_d  = CW'(W - 1);
                    if (bus.divisor == {W{1'b0}}) begin
                        state_d = DZ;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                r_d = r_next_s;
                q_d = q_next_s;
                if (cnt_q == {CW{1'b0}}) begin
                    quotient_d  = q_next_s;
                    remainder_d = r_next_s[W-1:0];
                    dbz_d       = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            DZ: begin
                quotient_d  = {W{1'b1}};
                remainder_d = q_q;
                dbz_d       = 1'b1;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_q         <= {(W+1){1'b0}};
            q_q         <= {W{1'b0}};
            div_q       <= {W{1'b0}};
            cnt_q       <= {CW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= {W{1'b0}};
            remainder_q <= {W{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Iterative unsigned restoring divider; the inverse operation of the team's 4x4 array multiplier.
- Takes a W-bit dividend and a W-bit divisor and produces a W-bit quotient and a W-bit remainder.
- Uses a start/busy/done handshake and retires one quotient bit per clock.
- Sits beside the multiplier behind the tt_um wrapper, with operands driven from ui_in/uio_in and results muxed to uo_out.

Parameters:
- W, 4, operand/result width in bits (supported range 2..8).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk edge.
- dividend  input  W  unsigned numerator; sampled only on an accepted start.
- divisor  input  W  unsigned denominator; sampled only on an accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse when results become valid.
- quotient  output  W  unsigned quotient; held until the next result.
- remainder  output  W  unsigned remainder; held until the next result.
- div_by_zero  output  1  set with done when divisor was 0; held with results.

Behaviour:
- One clock domain, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, FSM=IDLE. All internal registers are cleared.
- FSM states: IDLE, RUN, DZ.
- Acceptance:
  - start=1 at edge k while busy=0 is accepted.
  - Operands are latched at edge k.
  - busy=1 from edge k.
  - quotient, remainder and div_by_zero keep their previous values until the new result is written.
- IDLE to RUN: accepted start with divisor!=0.
  - Internal state: partial remainder R (W+1 bits) = 0, shift register Q = dividend, step counter = W-1.
- RUN, one step per edge:
  - R' = {R[W-1:0], Q[W-1]}; Q shifts left.
  - If R' >= {0,divisor}: R = R' - divisor and Q[0] = 1.
  - Otherwise: R = R' (restore) and Q[0] = 0.
  - The counter decrements each step.
  - The step taken with counter==0 is the last one. At that same edge:
    - quotient = final Q, remainder = final R[W-1:0], div_by_zero = 0.
    - busy goes to 0 and done goes to 1; next state is IDLE.
  - Latency: the result is visible at edge k+W (W clock edges after acceptance).
- IDLE to DZ: accepted start with divisor==0.
  - At edge k+1: quotient = all ones, remainder = dividend, div_by_zero = 1, busy = 0, done = 1; next state is IDLE.
  - Latency is 1 edge.
- done:
  - High for exactly one cycle, then it returns to 0.
  - It is never asserted in any other cycle.
- start while busy=1: ignored, with no effect on the operation in flight or on its operands.
- start in the cycle where done=1: accepted, because busy=0 in that cycle. done falls and busy rises at the next edge, which gives back-to-back throughput of one result per W+1 cycles.
- Operand inputs may change freely after acceptance; only latched copies are used.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). No done pulse is produced, and the partial result is discarded.
- Arithmetic invariant: for divisor!=0, dividend = quotient*divisor + remainder and remainder < divisor, exactly.
- The bench compares quotient, remainder and div_by_zero only when done=1.

Test Plan:
- Basic division, W=4: dividend=13, divisor=3, start pulsed at edge k -> busy=1 for edges k..k+3; at edge k+4 done=1 for one cycle with quotient=4, remainder=1, div_by_zero=0; busy=0.
- Boundary operands:
  - 15/1 -> q=15, r=0.
  - 2/7 -> q=0, r=2.
  - 15/15 -> q=1, r=0.
  - 0/5 -> q=0, r=0.
  - Each case gives done exactly W edges after start.
- Divide by zero: dividend=9, divisor=0 -> done at edge k+1 with quotient=15, remainder=9, div_by_zero=1; next start with 8/2 -> q=4, r=0, div_by_zero=0.
- Start while busy, and operand change after acceptance:
  - Start 13/3, then at edge k+2 drive start=1 with 6/2.
  - Inputs are also changed to 14/5 at edge k+1.
  - Required: still exactly one done at k+4 with q=4, r=1, and no second done.
- Back-to-back: assert start with 10/4 in the cycle where done=1 from a prior 7/2 (q=3, r=1) -> next done exactly 4 edges later with q=2, r=2.
- Reset mid-operation and exhaustive check:
  - Start 13/3, assert rst_n=0 between edges k+2 and k+3 -> outputs go to 0 immediately, no done; after release, 12/5 gives q=2, r=2.
  - Finally sweep all 256 operand pairs for W=4 against the reference model.
